alu_result_select_pipe: RTL and testbench

//  Parametrised N-channel result selector for the arithmetic/comparator datapath.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_result_select_pipe_skid_buffer_2.sv | 75 +++++++
 rtl/alu_result_select_pipe.sv | 79 +++++++
 tb/tb_alu_result_select_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: default channel geometry, result-select
// opcodes and the occupancy encoding of the 2-entry skid buffer.
package alu_pkg;

  localparam int unsigned ALU_WIDTH  = 4;
  localparam int unsigned ALU_NUM_CH = 4;

  localparam logic [1:0] SEL_ADD = 2'd0;
  localparam logic [1:0] SEL_SUB = 2'd1;
  localparam logic [1:0] SEL_CMP = 2'd2;
  localparam logic [1:0] SEL_RSV = 2'd3;

  // Buffer occupancy: number of stored entries (0, 1 or 2).
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_state_e;

endpackage

// File: rtl/alu_result_select_pipe_skid_buffer_2.sv
// skid_buffer_2: generic 2-entry valid/ready buffer.
//   in_data/in_valid/in_ready    : producer side, push = in_valid & in_ready
//   out_data/out_valid/out_ready : consumer side, pop = out_valid & out_ready
// in_ready and out_valid depend only on registered occupancy, so no
// combinational path exists from out_ready to in_ready.
module skid_buffer_2
  import alu_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  cnt_state_e    state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          push, pop;

  assign in_ready  = (state_q != CNT_FULL);
  assign out_valid = (state_q != CNT_EMPTY);
  assign out_data  = main_q;

  always_comb begin
    push    = in_valid & in_ready;
    pop     = out_valid & out_ready;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      CNT_EMPTY: begin
        if (push) begin
          main_d  = in_data;
          state_d = CNT_ONE;
        end
      end
      CNT_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          skid_d  = in_data;
          state_d = CNT_FULL;
        end else if (pop) begin
          state_d = CNT_EMPTY;
        end
      end
      CNT_FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = CNT_ONE;
        end
      end
      default: state_d = CNT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CNT_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/alu_result_select_pipe.sv
// alu_result_select_pipe: selects one of NUM_CH unit results by in_sel and
// registers it behind a 2-entry skid buffer.
//   in_data/in_sel/in_valid/in_ready        : request side
//   out_data/out_sel/out_err/out_valid/out_ready : result side
//   err_clr/err_cnt : saturating count of accepted out-of-range selects
module alu_result_select_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = ALU_WIDTH,
  parameter int unsigned NUM_CH = ALU_NUM_CH,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int unsigned PW = WIDTH + SEL_W + 1;
  // NUM_CH <= 2**SEL_W, so it always fits in SEL_W+1 bits.
  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W + 1)'(NUM_CH);

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [PW-1:0]    out_payload;
  logic             err_push;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Only in-range channels can match, so out-of-range selects leave 0.
  always_comb begin
    sel_err  = ({1'b0, in_sel} >= NUM_CH_L);
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (in_sel == SEL_W'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  skid_buffer_2 #(
    .PW (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({sel_err, in_sel, sel_data}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_payload),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign {out_err, out_sel, out_data} = out_payload;

  // Clear applies before counting, so clear plus an erroring push gives 1.
  always_comb begin
    err_push  = in_valid & in_ready & sel_err;
    cnt_base  = err_clr ? '0 : err_cnt_q;
    err_cnt_d = cnt_base;
    if (err_push && (cnt_base != '1)) err_cnt_d = cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_alu_result_select_pipe.sv
module tb_alu_result_select_pipe;

  localparam int W = 4, NC = 3, SW = 2, CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic          err;
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC*W-1:0] in_data;
  logic [SW-1:0]   in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_err;
  logic            out_valid;
  logic            out_ready;
  logic            err_clr;
  logic [CW-1:0]   err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  entry_t mq[$];
  int     merr = 0;

  always #5 clk = ~clk;

  alu_result_select_pipe #(
    .WIDTH  (W),
    .NUM_CH (NC),
    .SEL_W  (SW),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  function automatic logic [W-1:0] ref_pick(input logic [NC*W-1:0] d, input logic [SW-1:0] s);
    int unsigned v;
    if (int'(s) >= NC) return '0;
    v = (int'(d) >> (W * int'(s))) % (1 << W);
    return W'(v);
  endfunction

  // Drives one cycle of inputs, advances the reference model (FIFO of depth 2
  // plus saturating counter), then waits until just after the clock edge.
  task automatic step(input logic v, input logic [SW-1:0] s, input logic [NC*W-1:0] d,
                      input logic ordy, input logic clr, input logic r);
    entry_t e;
    bit push, pop;
    int base;
    rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy; err_clr = clr;
    if (r) begin
      mq.delete();
      merr = 0;
    end else begin
      push = v && (mq.size() < 2);
      pop  = ordy && (mq.size() > 0);
      e.err = (int'(s) >= NC); e.sel = s; e.data = ref_pick(d, s);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      base = clr ? 0 : merr;
      if (push && e.err && base < CMAX) base = base + 1;
      merr = base;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 2'd1, 12'hABC, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'd3, 12'h123, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 4'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_sel !== 2'd0) begin n_bad++; $display("FAIL reset_out_sel: got %h want 0", out_sel); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    n_cmp++; if (err_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_basic_select();
    step(1'b1, 2'd1, 12'h0A0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 4'hA) begin n_bad++; $display("FAIL basic_data: got %h want a", out_data); end
    n_cmp++; if (out_sel !== 2'd1) begin n_bad++; $display("FAIL basic_sel: got %0d want 1", out_sel); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", out_err); end
    step(1'b0, 2'd0, 12'h000, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    step(1'b1, 2'd0, 12'h003, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one: got %b want 1", in_ready); end
    step(1'b1, 2'd2, 12'h700, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
    n_cmp++; if (out_data !== 4'h3) begin n_bad++; $display("FAIL bp_hold_first: got %h want 3", out_data); end
    // stalled producer offers a different value that must not be taken
    step(1'b1, 2'd1, 12'h0F0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_data !== 4'h3) begin n_bad++; $display("FAIL bp_stable: got %h want 3", out_data); end
    step(1'b0, 2'd0, 12'h000, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_data !== 4'h7) begin n_bad++; $display("FAIL bp_second: got %h want 7", out_data); end
    n_cmp++; if (out_sel !== 2'd2) begin n_bad++; $display("FAIL bp_second_sel: got %0d want 2", out_sel); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop: got %b want 1", in_ready); end
    step(1'b0, 2'd0, 12'h000, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_err_clr();
    step(1'b1, 2'd3, 12'hFFF, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_data !== 4'h0) begin n_bad++; $display("FAIL err_data: got %h want 0", out_data); end
    n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b want 1", out_err); end
    n_cmp++; if (out_sel !== 2'd3) begin n_bad++; $display("FAIL err_sel: got %0d want 3", out_sel); end
    n_cmp++; if (err_cnt !== 2'd1) begin n_bad++; $display("FAIL err_cnt_first: got %0d want 1", err_cnt); end
    step(1'b1, 2'd3, 12'h555, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (err_cnt !== 2'd1) begin n_bad++; $display("FAIL err_clr_and_push: got %0d want 1", err_cnt); end
    step(1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (err_cnt !== 2'd0) begin n_bad++; $display("FAIL err_clr_only: got %0d want 0", err_cnt); end
  endtask

  task automatic test_saturate();
    int exp_seq[5] = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd3, 12'($urandom), 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (err_cnt !== CW'(exp_seq[i])) begin
        n_bad++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, err_cnt, exp_seq[i]);
      end
    end
    step(1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_stream();
    logic [NC*W-1:0] d;
    logic [SW-1:0]   s;
    logic [W-1:0]    exp_d;
    for (int i = 0; i < 16; i++) begin
      d = 12'($urandom);
      s = SW'($urandom_range(0, NC - 1));
      exp_d = ref_pick(d, s);
      step(1'b1, s, d, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_sel !== s) begin
        n_bad++; $display("FAIL stream[%0d]: got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                          i, out_valid, out_data, out_sel, exp_d, s);
      end
    end
    step(1'b0, 2'd0, 12'h000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic            v, ordy, clr, r;
    logic [SW-1:0]   s  = '0;
    logic [NC*W-1:0] d  = '0;
    logic            held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      clr  = ($urandom_range(0, 15) == 0);
      r    = ($urandom_range(0, 63) == 0);
      if (held) v = 1'b1;
      else begin
        s = SW'($urandom_range(0, 3));
        d = 12'($urandom);
      end
      held = v && !in_ready && !r;
      step(v, s, d, ordy, clr, r);
      if (r) held = 1'b0;
      n_cmp++;
      if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() != 2) || err_cnt !== CW'(merr)) begin
        n_bad++; $display("FAIL rand_ctrl[%0d]: got v=%b r=%b c=%0d want v=%b r=%b c=%0d", i,
                          out_valid, in_ready, err_cnt, mq.size() != 0, mq.size() != 2, merr);
      end
      if (mq.size() != 0) begin
        n_cmp++;
        if (out_data !== mq[0].data || out_sel !== mq[0].sel || out_err !== mq[0].err) begin
          n_bad++; $display("FAIL rand_data[%0d]: got d=%h s=%0d e=%b want d=%h s=%0d e=%b", i,
                            out_data, out_sel, out_err, mq[0].data, mq[0].sel, mq[0].err);
        end
      end
    end
    step(1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'd0, 12'h000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'd0, 12'h000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_full();
    step(1'b1, 2'd3, 12'h111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 12'h222, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rf_full: got %b want 0", in_ready); end
    n_cmp++; if (err_cnt !== 2'd2) begin n_bad++; $display("FAIL rf_cnt_before: got %0d want 2", err_cnt); end
    step(1'b1, 2'd3, 12'h333, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rf_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rf_ready: got %b want 1", in_ready); end
    n_cmp++; if (err_cnt !== 2'd0) begin n_bad++; $display("FAIL rf_cnt: got %0d want 0", err_cnt); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 12'h000, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rf_stale[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    step(1'b0, 2'd0, 12'h000, 1'b0, 1'b0, 1'b0);
    test_basic_select();
    test_backpressure();
    test_err_clr();
    test_saturate();
    test_stream();
    test_random();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
